// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - valid/ready bus bundle (N producers, one consumer) for rr_arb_mux
interface rr_arb_mux_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SELW-1:0] out_sel;
    logic           out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-input round-robin arbitrated registered mux with valid/ready; optional ARB_MUX_FORCE_EN
module rr_arb_mux #(
    parameter int N = 4,
    parameter int W = 32,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef ARB_MUX_FORCE_EN
    input  logic            force_en,
    input  logic [SELW-1:0] force_sel,
`endif
    rr_arb_mux_if.slave     bus
);

    logic [SELW-1:0] r_ptr;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_sel;

    logic            w_free;
    logic            w_any;
    logic            w_load;
    logic            w_forced;
    logic [SELW-1:0] w_gnt;
    logic [SELW-1:0] w_idx;
    logic [SELW-1:0] w_ptr_next;
    logic [W-1:0]    w_gnt_data;
    logic [N-1:0]    w_in_ready;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_any    = 1'b0;
        w_gnt    = '0;
        w_idx    = '0;
        w_forced = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = SELW'((int'(r_ptr) + k) % N);
            if (bus.in_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
`ifdef ARB_MUX_FORCE_EN
        if (force_en) begin
            w_forced = 1'b1;
            w_any    = 1'b0;
            w_gnt    = '0;
            for (int i = 0; i < N; i++) begin
                if (force_sel == SELW'(i) && bus.in_valid[i]) begin
                    w_any = 1'b1;
                    w_gnt = SELW'(i);
                end
            end
        end
`endif
    end

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt == SELW'(i)) begin
                w_gnt_data = bus.in_data[i*W +: W];
            end
        end
    end

    assign w_free     = !r_out_valid || bus.out_ready;
    assign w_load     = w_free && w_any;
    assign w_ptr_next = (w_gnt == SELW'(N - 1)) ? '0 : w_gnt + SELW'(1);

    // Gated by rst_n so no producer sees an accept while the block is held in reset.
    always_comb begin
        w_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            w_in_ready[i] = rst_n && w_load && (w_gnt == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt;
            if (!w_forced) begin
                r_ptr <= w_ptr_next;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - randomized and directed checks of rr_arb_mux against a priority-list model
module tb_rr_arb_mux;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arb_mux_if #(.N(N), .W(W)) bus_if ();

`ifdef ARB_MUX_FORCE_EN
    logic       force_en  = 1'b0;
    logic [1:0] force_sel = 2'd0;
`endif

    rr_arb_mux #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ARB_MUX_FORCE_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .bus       (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: channels kept in priority order; a granted channel goes to the back of the list.
    int         m_order[$];
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;

    function automatic void m_reset();
        m_order = {0, 1, 2, 3};
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
    endfunction

    function automatic int m_grant();
`ifdef ARB_MUX_FORCE_EN
        if (force_en) return bus_if.in_valid[force_sel] ? int'(force_sel) : -1;
`endif
        foreach (m_order[j]) begin
            if (bus_if.in_valid[m_order[j]]) return m_order[j];
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_in_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (rst_n !== 1'b1) return r;
        g = m_grant();
        if ((!m_valid || bus_if.out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    initial m_reset();
    always @(negedge rst_n) m_reset();

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            automatic int g = m_grant();
            automatic bit forced = 1'b0;
`ifdef ARB_MUX_FORCE_EN
            forced = force_en;
`endif
            if ((!m_valid || bus_if.out_ready) && g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus_if.in_data[g*W +: W];
                m_sel   = g;
                if (!forced) begin
                    while (m_order[0] != (g + 1) % N) m_order.push_back(m_order.pop_front());
                end
            end else if (m_valid && bus_if.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_out_valid", 32'(bus_if.out_valid), 32'(m_valid));
        check("cmp_out_data", 32'(bus_if.out_data), 32'(m_data));
        check("cmp_out_sel", 32'(bus_if.out_sel), 32'(m_sel));
        check("cmp_in_ready", 32'(bus_if.in_ready), 32'(m_in_ready()));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic data_inc();
        for (int i = 0; i < N; i++) bus_if.in_data[i*W +: W] = 8'(8'h10 + i);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_if.in_valid  = 4'($urandom);
        bus_if.in_data   = $urandom;
        bus_if.out_ready = 1'($urandom);
        repeat (2) step();
        #1;
        check("rst_out_valid", 32'(bus_if.out_valid), 0);
        check("rst_out_data", 32'(bus_if.out_data), 0);
        check("rst_out_sel", 32'(bus_if.out_sel), 0);
        check("rst_in_ready", 32'(bus_if.in_ready), 0);

        rst_n = 1'b1;
        bus_if.in_valid = 4'b0100;
        bus_if.in_data[2*W +: W] = 8'hA5;
        bus_if.out_ready = 1'b1;
        #1;
        check("first_in_ready", 32'(bus_if.in_ready), 32'b0100);
        step();
        check("first_valid", 32'(bus_if.out_valid), 1);
        check("first_data", 32'(bus_if.out_data), 32'hA5);
        check("first_sel", 32'(bus_if.out_sel), 2);

        pulse_reset();
        bus_if.in_valid = 4'b1111;
        data_inc();
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_valid", 32'(bus_if.out_valid), 1);
            check("rr_sel", 32'(bus_if.out_sel), 32'(k % 4));
            check("rr_data", 32'(bus_if.out_data), 32'(8'h10 + k % 4));
        end

        step();
        check("bp_load", 32'(bus_if.out_data), 32'h12);
        bus_if.out_ready = 1'b0;
        repeat (3) begin
            #1;
            check("bp_in_ready", 32'(bus_if.in_ready), 0);
            step();
            check("bp_hold_data", 32'(bus_if.out_data), 32'h12);
            check("bp_hold_valid", 32'(bus_if.out_valid), 1);
        end
        bus_if.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus_if.in_ready), 32'b1000);
        step();
        check("bp_release_data", 32'(bus_if.out_data), 32'h13);
        check("bp_release_sel", 32'(bus_if.out_sel), 3);

        bus_if.in_valid = 4'b0100;
        step();
        check("wrap_pre_sel", 32'(bus_if.out_sel), 2);
        bus_if.in_valid = 4'b0010;
        #1;
        check("skip_ready_1", 32'(bus_if.in_ready), 32'b0010);
        step();
        check("skip_sel_1", 32'(bus_if.out_sel), 1);
        bus_if.in_valid = 4'b1001;
        #1;
        check("skip_ready_3", 32'(bus_if.in_ready), 32'b1000);
        step();
        check("skip_sel_3", 32'(bus_if.out_sel), 3);
        bus_if.in_valid = 4'b1111;
        #1;
        check("wrap_ready_0", 32'(bus_if.in_ready), 32'b0001);
        step();
        check("wrap_sel_0", 32'(bus_if.out_sel), 0);

        bus_if.in_valid = 4'b0000;
        repeat (3) step();
        check("idle_valid", 32'(bus_if.out_valid), 0);
        check("idle_data_hold", 32'(bus_if.out_data), 32'h10);
        bus_if.in_valid = 4'b1111;
        #1;
        check("idle_ptr_kept", 32'(bus_if.in_ready), 32'b0010);

`ifdef ARB_MUX_FORCE_EN
        force_en  = 1'b1;
        force_sel = 2'd2;
        #1;
        check("force_ready", 32'(bus_if.in_ready), 32'b0100);
        repeat (3) begin
            step();
            check("force_sel", 32'(bus_if.out_sel), 2);
        end
        bus_if.in_valid = 4'b1011;
        #1;
        check("force_none", 32'(bus_if.in_ready), 0);
        force_en = 1'b0;
        bus_if.in_valid = 4'b1111;
        #1;
        check("force_resume", 32'(bus_if.in_ready), 32'b0010);
`endif

        step();
        check("ar_loaded", 32'(bus_if.out_valid), 1);
        bus_if.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_drop", 32'(bus_if.out_valid), 0);
        check("ar_in_ready", 32'(bus_if.in_ready), 0);
        step();
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        #1;
        check("ar_ready_0", 32'(bus_if.in_ready), 32'b0001);
        step();
        check("ar_sel_0", 32'(bus_if.out_sel), 0);

        repeat (3000) begin
            bus_if.in_valid  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            bus_if.in_data   = $urandom;
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
